// File: rtl/wash_phase_controller.sv
// wash_phase_controller
//   Wash-cycle sequencer. A coin starts the cycle, which runs
//   FILL -> WASH -> RINSE, optionally followed by a second WASH -> RINSE pass.
//   It then hands off to the external spin counter and finishes with a
//   one-cycle wash_done pulse. Timed phases are measured in seconds by an
//   internal prescaler. The prescaler's cycles-per-second value is latched at
//   coin time as BASE_CLK_HZ << clk_freq.
//
// Optional feature (macro PAUSE_ALL_PHASES_EN):
//   When defined, timer_pause also freezes the FILL/WASH/RINSE timers.
//   When undefined, timer_pause only matters in SPIN.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   soft_rst              synchronous clear, active-low, overrides all inputs
//   coin_in               start request, honoured only in IDLE
//   double_wash           extra wash+rinse pass, sampled with the coin
//   timer_pause           pause request
//   clk_freq[1:0]         clock scale 1x/2x/4x/8x, sampled with the coin
//   spining_done          end of spin, from the spin counter
//   start_spining         high throughout SPIN
//   spining_counter_stop  registered timer_pause while in SPIN
//   wash_done             one-cycle pulse in DONE
//   phase[2:0]            current state: IDLE=0 FILL=1 WASH=2 RINSE=3 SPIN=4 DONE=5
//
// Spin handshake: start_spining is a level request that stays high for as
//   long as the controller is in SPIN. spining_done is the completion strobe.
//   It is only observed while start_spining is high, and the controller leaves
//   SPIN on the following edge. There is no separate ready; the spin counter
//   is expected to be able to start whenever start_spining rises.
module wash_phase_controller #(
  parameter int unsigned BASE_CLK_HZ = 1_000_000,
  parameter int unsigned FILL_SEC    = 120,
  parameter int unsigned WASH_SEC    = 300,
  parameter int unsigned RINSE_SEC   = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_rst,
  input  logic       coin_in,
  input  logic       double_wash,
  input  logic       timer_pause,
  input  logic [1:0] clk_freq,
  input  logic       spining_done,
  output logic       start_spining,
  output logic       spining_counter_stop,
  output logic       wash_done,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [31:0] BASE_CPS   = 32'(BASE_CLK_HZ);
  localparam logic [31:0] FILL_LAST  = 32'(FILL_SEC - 1);
  localparam logic [31:0] WASH_LAST  = 32'(WASH_SEC - 1);
  localparam logic [31:0] RINSE_LAST = 32'(RINSE_SEC - 1);

  state_t      state;
  state_t      next_state;
  logic [31:0] cps_q;
  logic        dw_q;
  logic        pass2_q;
  logic [31:0] pre_cnt;
  logic [31:0] sec_cnt;

  logic        timed;
  logic [31:0] dur_last;
  logic        hold;
  logic        sec_tick;
  logic        phase_end;

  assign phase = state;

`ifdef PAUSE_ALL_PHASES_EN
  assign hold = timer_pause;
`else
  assign hold = 1'b0;
`endif

  // Which phases are timed, and the last seconds value of each.
  always_comb begin
    timed    = 1'b0;
    dur_last = '0;
    case (state)
      S_FILL:  begin timed = 1'b1; dur_last = FILL_LAST;  end
      S_WASH:  begin timed = 1'b1; dur_last = WASH_LAST;  end
      S_RINSE: begin timed = 1'b1; dur_last = RINSE_LAST; end
      default: begin timed = 1'b0; dur_last = '0;         end
    endcase
  end

  // A frozen prescaler never ticks, so a pause stretches the phase cycle for cycle.
  assign sec_tick  = timed && !hold && (pre_cnt == cps_q - 32'd1);
  assign phase_end = sec_tick && (sec_cnt == dur_last);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (coin_in) next_state = S_FILL;
      S_FILL:  if (phase_end) next_state = S_WASH;
      S_WASH:  if (phase_end) next_state = S_RINSE;
      S_RINSE: if (phase_end) next_state = (dw_q && !pass2_q) ? S_WASH : S_SPIN;
      S_SPIN:  if (spining_done) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      cps_q                <= '0;
      dw_q                 <= 1'b0;
      pass2_q              <= 1'b0;
      pre_cnt              <= '0;
      sec_cnt              <= '0;
      start_spining        <= 1'b0;
      spining_counter_stop <= 1'b0;
      wash_done            <= 1'b0;
    end else if (!soft_rst) begin
      state                <= S_IDLE;
      cps_q                <= '0;
      dw_q                 <= 1'b0;
      pass2_q              <= 1'b0;
      pre_cnt              <= '0;
      sec_cnt              <= '0;
      start_spining        <= 1'b0;
      spining_counter_stop <= 1'b0;
      wash_done            <= 1'b0;
    end else begin
      state                <= next_state;
      start_spining        <= (next_state == S_SPIN);
      wash_done            <= (next_state == S_DONE);
      spining_counter_stop <= (state == S_SPIN) && timer_pause;

      // Cycle configuration is frozen at the coin edge.
      if (state == S_IDLE && coin_in) begin
        cps_q   <= BASE_CPS << clk_freq;
        dw_q    <= double_wash;
        pass2_q <= 1'b0;
      end
      if (state == S_RINSE && next_state == S_WASH) pass2_q <= 1'b1;

      // Timers restart on every state entry.
      if (next_state != state) begin
        pre_cnt <= '0;
        sec_cnt <= '0;
      end else if (timed && !hold) begin
        if (sec_tick) begin
          pre_cnt <= '0;
          sec_cnt <= sec_cnt + 32'd1;
        end else begin
          pre_cnt <= pre_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wash_phase_controller.sv
// tb_wash_phase_controller
//   Drives complete wash cycles. For each cycle the bench expands the expected
//   phase timeline from the phase durations (seconds * cycles-per-second, plus
//   pause stretch when all-phase pause is built in). It then walks that
//   timeline one clock at a time, checking phase and the registered outputs.
module tb_wash_phase_controller;

  localparam int unsigned BASE  = 4;
  localparam int unsigned FILL  = 2;
  localparam int unsigned WASH  = 3;
  localparam int unsigned RINSE = 2;
`ifdef PAUSE_ALL_PHASES_EN
  localparam bit PAUSE_ALL = 1'b1;
`else
  localparam bit PAUSE_ALL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       soft_rst = 1'b1;
  logic       coin_in = 1'b0;
  logic       double_wash = 1'b0;
  logic       timer_pause = 1'b0;
  logic [1:0] clk_freq = 2'b00;
  logic       spining_done = 1'b0;
  logic       start_spining;
  logic       spining_counter_stop;
  logic       wash_done;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];

  // Clock and reset.
  always #5 clk = ~clk;

  wash_phase_controller #(
    .BASE_CLK_HZ(BASE),
    .FILL_SEC(FILL),
    .WASH_SEC(WASH),
    .RINSE_SEC(RINSE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .soft_rst(soft_rst),
    .coin_in(coin_in),
    .double_wash(double_wash),
    .timer_pause(timer_pause),
    .clk_freq(clk_freq),
    .spining_done(spining_done),
    .start_spining(start_spining),
    .spining_counter_stop(spining_counter_stop),
    .wash_done(wash_done),
    .phase(phase)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic push_phase(input logic [2:0] p, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(p);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_phase"}, 32'(phase), 32'd0);
    check({tag, "_start"}, 32'(start_spining), 32'd0);
    check({tag, "_stop"},  32'(spining_counter_stop), 32'd0);
    check({tag, "_done"},  32'(wash_done), 32'd0);
  endtask

  // One wash cycle.
  //   f, dw       clock scale and double wash presented with the coin
  //   pl          pause length driven in the first WASH, starting at its 3rd cycle
  //   spin_wait   SPIN cycles before spining_done takes effect
  //   sp_len      pause length driven in SPIN, starting at its 2nd cycle
  //   abort_idx   timeline index at which to abort (-1 = none)
  //   abort_async 1 = pulse rst, 0 = hold soft_rst low for one edge
  task automatic run_wash(input logic [1:0] f, input logic dw, input int pl,
                          input int spin_wait, input int sp_len,
                          input int abort_idx, input bit abort_async);
    int unsigned cps;
    int ps;
    int sp_start;
    int done_idx;
    int n;
    logic prev_pause;
    logic [2:0] prev_ph;
    logic [2:0] eph;

    exp_q.delete();
    cps = BASE << f;
    push_phase(3'd1, int'(FILL * cps));
    ps = exp_q.size() + 2;
    push_phase(3'd2, int'(WASH * cps) + (PAUSE_ALL ? pl : 0));
    push_phase(3'd3, int'(RINSE * cps));
    if (dw) begin
      push_phase(3'd2, int'(WASH * cps));
      push_phase(3'd3, int'(RINSE * cps));
    end
    sp_start = exp_q.size();
    push_phase(3'd4, spin_wait);
    push_phase(3'd5, 1);
    push_phase(3'd0, 2);
    done_idx = sp_start + spin_wait - 1;
    n = exp_q.size();

    @(negedge clk);
    coin_in = 1'b1;
    clk_freq = f;
    double_wash = dw;
    prev_pause = 1'b0;
    prev_ph = 3'd0;

    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      eph = exp_q.pop_front();
      if (i == 0) begin
        // Changes after the coin must be ignored.
        clk_freq = (f != 2'b00) ? 2'b00 : 2'b11;
        double_wash = ~dw;
      end
      check("phase", 32'(phase), 32'(eph));
      check("start_spining", 32'(start_spining), 32'(eph == 3'd4));
      check("wash_done", 32'(wash_done), 32'(eph == 3'd5));
      check("spin_stop", 32'(spining_counter_stop), 32'(prev_pause && prev_ph == 3'd4));
      prev_ph = eph;

      if (i == abort_idx) begin
        coin_in = 1'b0;
        timer_pause = 1'b0;
        spining_done = 1'b0;
        if (abort_async) begin
          #2 rst = 1'b1;
          #1 check_idle_outputs("async_rst");
          #1 rst = 1'b0;
        end else begin
          soft_rst = 1'b0;
          @(negedge clk);
          check_idle_outputs("soft_rst");
          soft_rst = 1'b1;
        end
        return;
      end

      coin_in = (i == 3);  // a coin during FILL must have no effect
      timer_pause = (i >= ps && i < ps + pl) ||
                    (i >= sp_start + 1 && i < sp_start + 1 + sp_len);
      spining_done = (i == done_idx);
      prev_pause = timer_pause;
    end
    coin_in = 1'b0;
    timer_pause = 1'b0;
    spining_done = 1'b0;
  endtask

  initial begin
    int spin;
    // Reset state.
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Coin and soft_rst together: soft_rst wins.
    coin_in = 1'b1;
    soft_rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("coin_vs_soft");
    coin_in = 1'b0;
    soft_rst = 1'b1;
    @(negedge clk);
    check("coin_vs_soft_hold", 32'(phase), 32'd0);

    // Single pass at 1x, with a WASH pause.
    run_wash(2'b00, 1'b0, 4, 5, 0, -1, 1'b0);
    // Double wash.
    run_wash(2'b00, 1'b1, 0, 3, 0, -1, 1'b0);
    // 4x clock, then clk_freq changed after the coin.
    run_wash(2'b10, 1'b0, 5, 4, 0, -1, 1'b0);
    // Six-cycle pause in SPIN.
    run_wash(2'b00, 1'b0, 0, 10, 6, -1, 1'b0);
    // soft_rst mid-RINSE, then a full cycle.
    run_wash(2'b00, 1'b0, 0, 5, 0, 23, 1'b0);
    run_wash(2'b00, 1'b0, 0, 5, 0, -1, 1'b0);
    // Async rst mid-SPIN while paused, then a full cycle.
    run_wash(2'b00, 1'b0, 0, 10, 5, 32, 1'b1);
    run_wash(2'b00, 1'b0, 0, 4, 2, -1, 1'b0);

    // Randomized cycles.
    for (int r = 0; r < 6; r++) begin
      spin = int'($urandom_range(3, 12));
      run_wash(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 5)), spin,
               int'($urandom_range(0, spin - 2)), -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
